// File: rtl/vga_pkg.sv
// Shared VRAM arbitration types and constants for the character display path.
// Readout slot reservation lives here so every VRAM client agrees on it.
package vga_pkg;

    localparam int unsigned VRAM_ADDR_W = 13;
    localparam int unsigned VRAM_DATA_W = 8;

    // Phases 1 and 5 of the 8-cycle fetch period belong to the readout path.
    localparam logic [7:0] RD_SLOT_MASK_DEFAULT = 8'b0010_0010;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RDWAIT,
        ACK
    } arb_state_t;

    function automatic logic slotReserved(
        input logic [7:0] mask,
        input logic       active,
        input logic [2:0] phase
    );
        return active & mask[phase];
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between display readout and the host port.
// Readout slots always win; host ops fill the remaining cycles of the fetch period.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W           = VRAM_ADDR_W,
    parameter int unsigned DATA_W           = VRAM_DATA_W,
    parameter logic [7:0]  RD_SLOT_MASK     = RD_SLOT_MASK_DEFAULT,
    parameter bit          WRITE_BLANK_ONLY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdActive,
    input  logic [2:0]        rdPhase,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic              hostReq,
    input  logic              hostWe,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostWdata,
    output logic              hostAck,
    output logic [DATA_W-1:0] hostRdata,
    output logic [ADDR_W-1:0] vramAddr,
    output logic              vramWe,
    output logic [DATA_W-1:0] vramWdata,
    input  logic [DATA_W-1:0] vramRdata
);

    arb_state_t        state;
    logic              latWe;
    logic [ADDR_W-1:0] latAddr;
    logic [DATA_W-1:0] latData;

    logic reserved;
    logic hostFree;
    logic issue;

    always_comb begin
        reserved  = slotReserved(RD_SLOT_MASK, rdActive, rdPhase);
        // Blank-only writes additionally need the readout to be idle this cycle.
        hostFree  = !reserved && !(WRITE_BLANK_ONLY && latWe && rdActive);
        issue     = (state == PEND) && hostFree;
        vramAddr  = issue ? latAddr : rdAddr;
        vramWe    = issue && latWe;
        vramWdata = latData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            latWe     <= 1'b0;
            latAddr   <= '0;
            latData   <= '0;
            hostAck   <= 1'b0;
            hostRdata <= '0;
        end else begin
            hostAck <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hostReq) begin
                        latWe   <= hostWe;
                        latAddr <= hostAddr;
                        latData <= hostWdata;
                        state   <= PEND;
                    end
                end
                PEND: begin
                    if (hostFree) begin
                        if (latWe) begin
                            hostAck <= 1'b1;
                            state   <= ACK;
                        end else begin
                            state <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    // VRAM returns data one cycle after the issue cycle.
                    hostRdata <= vramRdata;
                    hostAck   <= 1'b1;
                    state     <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
